lsu_axi_demux: RTL and testbench

- Load/store unit for the MEM stage; successor to the two-target (SRAM + UART) data-memory front end.
- Accepts one memory op per handshake from EXU and wins the shared bus through the arbiter request/grant pair.
- Address-decodes to one of NUM_SLAVES AXI4-Lite targets, drives only that target, then returns aligned, extended load data to WBU.
- Adds: parametrised width and slave count, decode-error reporting, misalignment trap, single-cycle bypass for non-memory ops.

---
 rtl/lsu_axi_demux_pkg.sv | 35 +++
 rtl/lsu_addr_decode.sv | 26 ++
 rtl/lsu_axi_demux.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_lsu_axi_demux.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_axi_demux_pkg.sv
// Shared types and constants for the MEM-stage load/store unit and its address decoder.
package lsu_axi_demux_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_GRANT,
        S_AR,
        S_R,
        S_AW_W,
        S_B,
        S_RESP
    } lsu_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_SLAVE    = 2'b10;
    localparam logic [1:0] ERR_DECODE   = 2'b11;

    // funct3[1:0] selects the access size, funct3[2] selects zero extension
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;
    localparam int         F3_UNSIGNED_BIT = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int size_bytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

endpackage

// File: rtl/lsu_addr_decode.sv
// Combinational address decoder: one-hot slave select plus hit flag.
// Slave 0 is the leftmost entry of SLV_BASE/SLV_MASK; the lowest index wins on overlap.
module lsu_addr_decode #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*DATA_WIDTH-1:0] SLV_BASE = {32'h1000_0000, 32'h8000_0000},
    parameter logic [NUM_SLAVES*DATA_WIDTH-1:0] SLV_MASK = {32'hFFFF_F000, 32'hF800_0000}
) (
    input  logic [DATA_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  hit
);

    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((addr & SLV_MASK[(NUM_SLAVES-1-i)*DATA_WIDTH +: DATA_WIDTH])
                         == SLV_BASE[(NUM_SLAVES-1-i)*DATA_WIDTH +: DATA_WIDTH])) begin
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsu_axi_demux.sv
// MEM-stage load/store unit: one op per handshake, routed to one AXI4-Lite slave.
// Optional watchdog on bus phases is enabled by defining LSU_TIMEOUT_EN.
module lsu_axi_demux
    import lsu_axi_demux_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*DATA_WIDTH-1:0] SLV_BASE = {32'h1000_0000, 32'h8000_0000},
    parameter logic [NUM_SLAVES*DATA_WIDTH-1:0] SLV_MASK = {32'hFFFF_F000, 32'hF800_0000},
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            addr,
    input  logic                             mem_read,
    input  logic                             mem_write,
    input  logic [2:0]                       funct3,
    input  logic [DATA_WIDTH-1:0]            st_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            ld_data,
    output logic                             err,
    output logic [1:0]                       err_code,
    output logic                             arb_req,
    input  logic                             arb_grant,
    output logic [DATA_WIDTH-1:0]            m_araddr,
    output logic [DATA_WIDTH-1:0]            m_awaddr,
    output logic [DATA_WIDTH-1:0]            m_wdata,
    output logic [DATA_WIDTH/8-1:0]          m_wstrb,
    output logic [NUM_SLAVES-1:0]            m_arvalid,
    output logic [NUM_SLAVES-1:0]            m_awvalid,
    output logic [NUM_SLAVES-1:0]            m_wvalid,
    output logic [NUM_SLAVES-1:0]            m_rready,
    output logic [NUM_SLAVES-1:0]            m_bready,
    input  logic [NUM_SLAVES-1:0]            s_arready,
    input  logic [NUM_SLAVES-1:0]            s_awready,
    input  logic [NUM_SLAVES-1:0]            s_wready,
    input  logic [NUM_SLAVES-1:0]            s_rvalid,
    input  logic [NUM_SLAVES-1:0]            s_bvalid,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES*2-1:0]          s_rresp,
    input  logic [NUM_SLAVES*2-1:0]          s_bresp
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    lsu_state_t              state;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [2:0]              funct3_q;
    logic                    is_read_q;
    logic                    is_write_q;
    logic [NUM_SLAVES-1:0]   sel_q;
    logic                    hit_q;

    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    dec_hit;
    logic                    misaligned;
    logic [STRB_W-1:0]       strb_next;
    logic [DATA_WIDTH-1:0]   wdata_rep;
    logic [DATA_WIDTH-1:0]   rdata_sel;
    logic [1:0]              rresp_sel;
    logic [1:0]              bresp_sel;
    logic [DATA_WIDTH-1:0]   ld_ext;
    logic                    ar_fire, r_fire, aw_fire, w_fire, b_fire;
    logic                    aw_done, w_done;

    lsu_addr_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decode (
        .addr (addr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    assign m_araddr = addr_q;
    assign m_awaddr = addr_q;

    always_comb begin
        case (funct3_q[1:0])
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = addr_q[0];
            SZ_W:    misaligned = |addr_q[1:0];
            default: misaligned = (DATA_WIDTH == 32) ? 1'b1 : |addr_q[2:0];
        endcase
    end

    // Aligned stores land on lanes that are a multiple of the size, so lane j takes byte j mod size
    always_comb begin
        int nb_in;
        logic [STRB_W-1:0] size_mask;
        nb_in     = size_bytes(funct3[1:0]);
        size_mask = '0;
        wdata_rep = '0;
        for (int j = 0; j < STRB_W; j++) begin
            size_mask[j]        = (j < nb_in);
            wdata_rep[j*8 +: 8] = st_data[(j % nb_in)*8 +: 8];
        end
        strb_next = size_mask << addr[OFF_W-1:0];
    end

    always_comb begin
        int nb;
        logic [DATA_WIDTH-1:0] shifted;
        logic [DATA_WIDTH-1:0] keep;
        rdata_sel = '0;
        rresp_sel = '0;
        bresp_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                rdata_sel = rdata_sel | s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                rresp_sel = rresp_sel | s_rresp[i*2 +: 2];
                bresp_sel = bresp_sel | s_bresp[i*2 +: 2];
            end
        end
        shifted = rdata_sel >> {addr_q[OFF_W-1:0], 3'b000};
        nb      = size_bytes(funct3_q[1:0]);
        if (nb > STRB_W) nb = STRB_W;
        keep = '0;
        for (int j = 0; j < STRB_W; j++) begin
            keep[j*8 +: 8] = (j < nb) ? 8'hFF : 8'h00;
        end
        ld_ext = shifted & keep;
        if (!funct3_q[F3_UNSIGNED_BIT] && shifted[nb*8-1]) ld_ext = ld_ext | ~keep;
    end

    assign ar_fire = |(m_arvalid & s_arready);
    assign r_fire  = |(m_rready  & s_rvalid);
    assign aw_fire = |(m_awvalid & s_awready);
    assign w_fire  = |(m_wvalid  & s_wready);
    assign b_fire  = |(m_bready  & s_bvalid);
    assign aw_done = (m_awvalid == '0) || aw_fire;
    assign w_done  = (m_wvalid  == '0) || w_fire;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    // Single FSM; every output is a register updated on the transition that needs it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            ld_data    <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            arb_req    <= 1'b0;
            m_arvalid  <= '0;
            m_awvalid  <= '0;
            m_wvalid   <= '0;
            m_rready   <= '0;
            m_bready   <= '0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
            addr_q     <= '0;
            funct3_q   <= '0;
            is_read_q  <= 1'b0;
            is_write_q <= 1'b0;
            sel_q      <= '0;
            hit_q      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        addr_q     <= addr;
                        funct3_q   <= funct3;
                        is_read_q  <= mem_read;
                        is_write_q <= mem_write & ~mem_read;
                        sel_q      <= dec_sel;
                        hit_q      <= dec_hit;
                        m_wdata    <= wdata_rep;
                        m_wstrb    <= strb_next;
                        in_ready   <= 1'b0;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!is_read_q && !is_write_q) begin
                        ld_data   <= '0;
                        err       <= 1'b0;
                        err_code  <= ERR_NONE;
                        out_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (misaligned) begin
                        ld_data   <= '0;
                        err       <= 1'b1;
                        err_code  <= ERR_MISALIGN;
                        out_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (!hit_q) begin
                        ld_data   <= '0;
                        err       <= 1'b1;
                        err_code  <= ERR_DECODE;
                        out_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        arb_req <= 1'b1;
                        state   <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (arb_grant) begin
                        if (is_read_q) begin
                            m_arvalid <= sel_q;
                            state     <= S_AR;
                        end else begin
                            m_awvalid <= sel_q;
                            m_wvalid  <= sel_q;
                            state     <= S_AW_W;
                        end
                    end
                end
                S_AR: begin
                    if (ar_fire) begin
                        m_arvalid <= '0;
                        m_rready  <= sel_q;
                        state     <= S_R;
                    end
                end
                S_R: begin
                    if (r_fire) begin
                        m_rready  <= '0;
                        arb_req   <= 1'b0;
                        ld_data   <= ld_ext;
                        err       <= (rresp_sel != RESP_OKAY);
                        err_code  <= (rresp_sel != RESP_OKAY) ? ERR_SLAVE : ERR_NONE;
                        out_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_AW_W: begin
                    if (aw_fire) m_awvalid <= '0;
                    if (w_fire)  m_wvalid  <= '0;
                    if (aw_done && w_done) begin
                        m_bready <= sel_q;
                        state    <= S_B;
                    end
                end
                S_B: begin
                    if (b_fire) begin
                        m_bready  <= '0;
                        arb_req   <= 1'b0;
                        ld_data   <= '0;
                        err       <= (bresp_sel != RESP_OKAY);
                        err_code  <= (bresp_sel != RESP_OKAY) ? ERR_SLAVE : ERR_NONE;
                        out_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef LSU_TIMEOUT_EN
            // Placed after the case so an expiring watchdog overrides any bus-phase update
            if (state == S_AR || state == S_R || state == S_AW_W || state == S_B) begin
                if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    m_arvalid <= '0;
                    m_awvalid <= '0;
                    m_wvalid  <= '0;
                    m_rready  <= '0;
                    m_bready  <= '0;
                    arb_req   <= 1'b0;
                    ld_data   <= '0;
                    err       <= 1'b1;
                    err_code  <= ERR_DECODE;
                    out_valid <= 1'b1;
                    state     <= S_RESP;
                    tmo_cnt   <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_lsu_axi_demux.sv
// Directed self-checking bench for lsu_axi_demux with a small responsive AXI4-Lite slave model.
module tb_lsu_axi_demux;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready;
    logic [31:0] addr;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] st_data;
    logic        out_valid, out_ready;
    logic [31:0] ld_data;
    logic        err;
    logic [1:0]  err_code;
    logic        arb_req, arb_grant;
    logic [31:0] m_araddr, m_awaddr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready;
    logic [1:0]  s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
    logic [63:0] s_rdata;
    logic [3:0]  s_rresp, s_bresp;

    logic [31:0] rd_val0, rd_val1;
    logic [1:0]  resp_val;
    logic        silent, r_silent;
    int          w_delay, w_wait;
    logic [1:0]  arv_seen, awv_seen, wv_seen, anyv_seen;
    logic        arb_seen, w_alone;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    assign arb_grant = arb_req;
    assign s_rdata   = {rd_val1, rd_val0};
    assign s_rresp   = {resp_val, resp_val};
    assign s_bresp   = {resp_val, resp_val};

    lsu_axi_demux dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .addr(addr),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .st_data(st_data),
        .out_valid(out_valid), .out_ready(out_ready), .ld_data(ld_data),
        .err(err), .err_code(err_code), .arb_req(arb_req), .arb_grant(arb_grant),
        .m_araddr(m_araddr), .m_awaddr(m_awaddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_arvalid(m_arvalid), .m_awvalid(m_awvalid), .m_wvalid(m_wvalid),
        .m_rready(m_rready), .m_bready(m_bready),
        .s_arready(s_arready), .s_awready(s_awready), .s_wready(s_wready),
        .s_rvalid(s_rvalid), .s_bvalid(s_bvalid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_bresp(s_bresp)
    );

    // Slave model answers half a cycle after the DUT raises a valid/ready
    always @(negedge clk) begin
        if (m_wvalid != 2'b00) w_wait = w_wait + 1; else w_wait = 0;
        s_arready = silent ? 2'b00 : m_arvalid;
        s_rvalid  = (silent || r_silent) ? 2'b00 : m_rready;
        s_awready = silent ? 2'b00 : m_awvalid;
        s_wready  = (silent || w_wait <= w_delay) ? 2'b00 : m_wvalid;
        s_bvalid  = silent ? 2'b00 : m_bready;
        arv_seen  = arv_seen | m_arvalid;
        awv_seen  = awv_seen | m_awvalid;
        wv_seen   = wv_seen | m_wvalid;
        anyv_seen = anyv_seen | m_arvalid | m_awvalid | m_wvalid | m_rready | m_bready;
        arb_seen  = arb_seen | arb_req;
        if (m_wvalid != 2'b00 && m_awvalid == 2'b00) w_alone = 1'b1;
    end

    task automatic clear_mon();
        arv_seen = '0; awv_seen = '0; wv_seen = '0; anyv_seen = '0;
        arb_seen = 1'b0; w_alone = 1'b0;
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [2:0] f3, input logic [31:0] d,
                          output int lat, output logic got);
        clear_mon();
        @(negedge clk);
        in_valid = 1'b1; mem_read = rd; mem_write = wr; addr = a; funct3 = f3; st_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        got = out_valid;
    endtask

    task automatic complete_resp();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0 || err !== 1'b0) $display("[TB] FAIL reset_out got valid=%b err=%b want 0 0", out_valid, err); else n_pass++;
        n_checks++; if (ld_data !== 32'h0 || err_code !== 2'b00) $display("[TB] FAIL reset_data got %h/%b want 0/00", ld_data, err_code); else n_pass++;
        n_checks++; if (arb_req !== 1'b0) $display("[TB] FAIL reset_arb got %b want 0", arb_req); else n_pass++;
        n_checks++; if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 10'h0) $display("[TB] FAIL reset_bus got %b want 0", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}); else n_pass++;
    endtask

    task automatic test_lw();
        int lat; logic got;
        rd_val1 = 32'hDEAD_BEEF; rd_val0 = 32'h5555_5555; resp_val = 2'b00;
        run_op(1'b1, 1'b0, 32'h8000_0004, 3'b010, 32'h0, lat, got);
        n_checks++; if (got !== 1'b1) $display("[TB] FAIL lw_resp got out_valid=%b want 1", got); else n_pass++;
        n_checks++; if (lat != 5) $display("[TB] FAIL lw_latency got %0d want 5", lat); else n_pass++;
        n_checks++; if (ld_data !== 32'hDEAD_BEEF) $display("[TB] FAIL lw_data got %h want deadbeef", ld_data); else n_pass++;
        n_checks++; if (err !== 1'b0 || err_code !== 2'b00) $display("[TB] FAIL lw_err got %b/%b want 0/00", err, err_code); else n_pass++;
        n_checks++; if (arv_seen !== 2'b10) $display("[TB] FAIL lw_arvalid_sel got %b want 10", arv_seen); else n_pass++;
        n_checks++; if (m_araddr !== 32'h8000_0004) $display("[TB] FAIL lw_araddr got %h want 80000004", m_araddr); else n_pass++;
        complete_resp();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL lw_done got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); else n_pass++;
    endtask

    task automatic test_load_extend();
        logic [31:0] t_addr [6] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h8000_0002, 32'h8000_0001, 32'h1000_0000};
        logic [2:0]  t_f3   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b100};
        logic [31:0] t_rd   [6] = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h80FF_FFFF, 32'h80FF_FFFF, 32'h1234_5678, 32'h1234_56F8};
        logic [31:0] t_exp  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_0056, 32'h0000_00F8};
        int lat; logic got;
        for (int k = 0; k < 6; k++) begin
            rd_val1 = t_addr[k][31] ? t_rd[k] : ~t_rd[k];
            rd_val0 = t_addr[k][31] ? ~t_rd[k] : t_rd[k];
            run_op(1'b1, 1'b0, t_addr[k], t_f3[k], 32'h0, lat, got);
            n_checks++; if (got !== 1'b1 || ld_data !== t_exp[k]) $display("[TB] FAIL ext_%0d got valid=%b data=%h want 1 %h", k, got, ld_data, t_exp[k]); else n_pass++;
            complete_resp();
        end
    endtask

    task automatic test_store();
        logic [31:0] t_addr [3] = '{32'h1000_0002, 32'h1000_0001, 32'h8000_0004};
        logic [2:0]  t_f3   [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] t_dat  [3] = '{32'h0000_1234, 32'h0000_00AB, 32'hCAFE_F00D};
        logic [3:0]  t_strb [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] t_wd   [3] = '{32'h1234_1234, 32'hABAB_ABAB, 32'hCAFE_F00D};
        logic [1:0]  t_sel  [3] = '{2'b01, 2'b01, 2'b10};
        int          t_wdl  [3] = '{1, 0, 0};
        int lat; logic got; logic extra;
        for (int k = 0; k < 3; k++) begin
            w_delay = t_wdl[k];
            run_op(1'b0, 1'b1, t_addr[k], t_f3[k], t_dat[k], lat, got);
            n_checks++; if (got !== 1'b1 || err !== 1'b0) $display("[TB] FAIL st_%0d_resp got valid=%b err=%b want 1 0", k, got, err); else n_pass++;
            n_checks++; if (m_wstrb !== t_strb[k] || m_wdata !== t_wd[k]) $display("[TB] FAIL st_%0d_lanes got %b/%h want %b/%h", k, m_wstrb, m_wdata, t_strb[k], t_wd[k]); else n_pass++;
            n_checks++; if (awv_seen !== t_sel[k] || wv_seen !== t_sel[k]) $display("[TB] FAIL st_%0d_sel got aw=%b w=%b want %b", k, awv_seen, wv_seen, t_sel[k]); else n_pass++;
            if (k == 0) begin
                n_checks++; if (w_alone !== 1'b1) $display("[TB] FAIL st_aw_first got %b want 1", w_alone); else n_pass++;
                n_checks++; if (m_awaddr !== 32'h1000_0002) $display("[TB] FAIL st_awaddr got %h want 10000002", m_awaddr); else n_pass++;
            end
            complete_resp();
            extra = 1'b0;
            repeat (3) begin @(posedge clk); #1; extra = extra | out_valid; end
            n_checks++; if (extra !== 1'b0) $display("[TB] FAIL st_%0d_single got extra out_valid=%b want 0", k, extra); else n_pass++;
        end
        w_delay = 0;
    endtask

    task automatic test_errors();
        int lat; logic got;
        run_op(1'b1, 1'b0, 32'h8000_0001, 3'b010, 32'h0, lat, got);
        n_checks++; if (got !== 1'b1 || err !== 1'b1 || err_code !== 2'b01) $display("[TB] FAIL misalign got valid=%b err=%b code=%b want 1 1 01", got, err, err_code); else n_pass++;
        n_checks++; if (arb_seen !== 1'b0 || anyv_seen !== 2'b00) $display("[TB] FAIL misalign_bus got arb=%b bus=%b want 0 00", arb_seen, anyv_seen); else n_pass++;
        complete_resp();
        run_op(1'b1, 1'b0, 32'h4000_0000, 3'b010, 32'h0, lat, got);
        n_checks++; if (got !== 1'b1 || err_code !== 2'b11) $display("[TB] FAIL decode got valid=%b code=%b want 1 11", got, err_code); else n_pass++;
        n_checks++; if (arb_seen !== 1'b0 || anyv_seen !== 2'b00) $display("[TB] FAIL decode_bus got arb=%b bus=%b want 0 00", arb_seen, anyv_seen); else n_pass++;
        complete_resp();
        run_op(1'b1, 1'b0, 32'h8000_0000, 3'b011, 32'h0, lat, got);
        n_checks++; if (err_code !== 2'b01) $display("[TB] FAIL ld_on_rv32 got code=%b want 01", err_code); else n_pass++;
        complete_resp();
        run_op(1'b0, 1'b0, 32'h8000_0004, 3'b010, 32'h1234_5678, lat, got);
        n_checks++; if (lat != 2 || err !== 1'b0 || ld_data !== 32'h0) $display("[TB] FAIL bypass got lat=%0d err=%b data=%h want 2 0 0", lat, err, ld_data); else n_pass++;
        n_checks++; if (arb_seen !== 1'b0) $display("[TB] FAIL bypass_arb got %b want 0", arb_seen); else n_pass++;
        complete_resp();
    endtask

    task automatic test_stall_slverr();
        int lat; logic got;
        resp_val = 2'b10; out_ready = 1'b0;
        run_op(1'b0, 1'b1, 32'h8000_0000, 3'b010, 32'h1122_3344, lat, got);
        n_checks++; if (got !== 1'b1) $display("[TB] FAIL slverr_resp got %b want 1", got); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1 || err_code !== 2'b10 || in_ready !== 1'b0) $display("[TB] FAIL stall_%0d got valid=%b code=%b in_ready=%b want 1 10 0", c, out_valid, err_code, in_ready); else n_pass++;
        end
        out_ready = 1'b1; resp_val = 2'b00;
        complete_resp();
        n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL stall_release got in_ready=%b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc; logic extra; int lat; logic got;
        r_silent = 1'b1; rd_val1 = 32'h0BAD_0BAD;
        clear_mon();
        @(negedge clk);
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 32'h8000_0008; funct3 = 3'b010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (m_rready == 2'b00 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        n_checks++; if (m_rready !== 2'b10) $display("[TB] FAIL mid_reach_r got rready=%b want 10", m_rready); else n_pass++;
        rstn = 1'b0; #1;
        n_checks++; if (m_rready !== 2'b00 || arb_req !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL mid_reset got rready=%b arb=%b in_ready=%b valid=%b want 00 0 1 0", m_rready, arb_req, in_ready, out_valid); else n_pass++;
        @(negedge clk); rstn = 1'b1; r_silent = 1'b0;
        extra = 1'b0;
        repeat (4) begin @(posedge clk); #1; extra = extra | out_valid; end
        n_checks++; if (extra !== 1'b0) $display("[TB] FAIL mid_no_resp got out_valid=%b want 0", extra); else n_pass++;
        rd_val1 = 32'h1357_9BDF;
        run_op(1'b1, 1'b0, 32'h8000_0004, 3'b010, 32'h0, lat, got);
        n_checks++; if (got !== 1'b1 || ld_data !== 32'h1357_9BDF || err !== 1'b0) $display("[TB] FAIL mid_next got valid=%b data=%h err=%b want 1 13579bdf 0", got, ld_data, err); else n_pass++;
        complete_resp();
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int lat; logic got;
        silent = 1'b1;
        run_op(1'b1, 1'b0, 32'h8000_0000, 3'b010, 32'h0, lat, got);
        n_checks++; if (got !== 1'b1 || err_code !== 2'b11 || m_arvalid !== 2'b00) $display("[TB] FAIL timeout got valid=%b code=%b arvalid=%b want 1 11 00", got, err_code, m_arvalid); else n_pass++;
        silent = 1'b0;
        complete_resp();
    endtask
`endif

    initial begin
        rstn = 1'b0; in_valid = 1'b0; addr = '0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = '0; st_data = '0; out_ready = 1'b1;
        rd_val0 = '0; rd_val1 = '0; resp_val = 2'b00; silent = 1'b0; r_silent = 1'b0;
        w_delay = 0; w_wait = 0;
        s_arready = '0; s_awready = '0; s_wready = '0; s_rvalid = '0; s_bvalid = '0;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rstn = 1'b1;
        test_lw();
        test_load_extend();
        test_store();
        test_errors();
        test_stall_slverr();
        test_reset_mid();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
